// File: rtl/wire_cmd_pkg.sv
// wire_cmd_pkg: opcodes, FSM state encoding and status bit positions shared by the responder.
package wire_cmd_pkg;
   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_MUL = 3'd2;
   localparam logic [2:0] OP_ACC = 3'd3;
   localparam logic [2:0] OP_CLR = 3'd4;
   localparam logic [2:0] S_INIT = 3'd0;
   localparam logic [2:0] S_IDLE = 3'd1;
   localparam logic [2:0] S_EXEC = 3'd2;
   localparam logic [2:0] S_MUL  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;
   localparam int ST_ACK     = 31;
   localparam int ST_BUSY    = 30;
   localparam int ST_ILL     = 29;
   localparam int ST_OVR     = 28;
   localparam int ST_CY      = 27;
   localparam int ST_OPC_LSB = 24;
endpackage

// File: rtl/shift_add_mul32.sv
// shift_add_mul32: iterative 32x32 multiplier keeping the low 32 product bits.
module shift_add_mul32 #(
   parameter int ITER = 32
) (
   input  logic        okClk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        done,
   output logic [31:0] p
);
   localparam int CW = $clog2(ITER + 1);
   logic [31:0] mc_q, mc_d, mp_q, mp_d, p_q, p_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic run_q, run_d;
   // done is raised during the final iteration so p is ready on the edge that ends it
   assign done = run_q && cnt_q == CW'(ITER - 1);
   assign p = p_q;
   always_comb begin
      mc_d = mc_q;
      mp_d = mp_q;
      p_d = p_q;
      cnt_d = cnt_q;
      run_d = run_q;
      if (start) begin
         mc_d = a;
         mp_d = b;
         p_d = '0;
         cnt_d = '0;
         run_d = 1'b1;
      end else if (run_q) begin
         p_d = p_q + (mp_q[0] ? mc_q : 32'd0);
         mc_d = mc_q << 1;
         mp_d = mp_q >> 1;
         cnt_d = cnt_q + CW'(1);
         run_d = !done;
      end
   end
   always_ff @(posedge okClk or negedge rst_n) begin
      if (!rst_n) begin
         mc_q <= '0;
         mp_q <= '0;
         p_q <= '0;
         cnt_q <= '0;
         run_q <= 1'b0;
      end else begin
         mc_q <= mc_d;
         mp_q <= mp_d;
         p_q <= p_d;
         cnt_q <= cnt_d;
         run_q <= run_d;
      end
   end
endmodule

// File: rtl/wire_cmd_responder.sv
// wire_cmd_responder: toggle-handshake command executor between FrontPanel WireIns and WireOuts.
module wire_cmd_responder
   import wire_cmd_pkg::*;
#(
   parameter int CNT_W    = 16,
   parameter int MUL_ITER = 32
) (
   input  logic        okClk,
   input  logic        rst_n,
   input  logic [31:0] cmd_word,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   output logic [31:0] result,
   output logic [31:0] status
);
   logic [2:0] state_q, state_d, opc_q, opc_d, lop_q, lop_d;
   logic [31:0] a_q, a_d, b_q, b_d, acc_q, acc_d, stg_q, stg_d, res_q, res_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic req_last_q, req_last_d, stg_cy_q, stg_cy_d, ack_q, ack_d, busy_q, busy_d;
   logic ill_q, ill_d, ovr_q, ovr_d, cy_q, cy_d;
   logic req, mul_start, mul_done, arith;
   logic [31:0] mul_p;
   logic [32:0] add_s, acc_s;
   logic cmd_unused;
   assign cmd_unused = ^cmd_word[30:3];
   assign req = cmd_word[31] != req_last_q;
   assign add_s = {1'b0, a_q} + {1'b0, b_q};
   assign acc_s = {1'b0, acc_q} + {1'b0, a_q};
   assign arith = opc_q == OP_ADD || opc_q == OP_SUB || opc_q == OP_ACC;
   shift_add_mul32 #(.ITER(MUL_ITER)) u_mul (
      .okClk(okClk),
      .rst_n(rst_n),
      .start(mul_start),
      .a(a_q),
      .b(b_q),
      .done(mul_done),
      .p(mul_p)
   );
   always_comb begin
      state_d = state_q;
      req_last_d = req_last_q;
      a_d = a_q;
      b_d = b_q;
      opc_d = opc_q;
      acc_d = acc_q;
      stg_d = stg_q;
      stg_cy_d = stg_cy_q;
      res_d = res_q;
      cnt_d = cnt_q;
      ack_d = ack_q;
      busy_d = busy_q;
      ill_d = ill_q;
      ovr_d = ovr_q;
      cy_d = cy_q;
      lop_d = lop_q;
      mul_start = 1'b0;
      case (state_q)
         S_INIT: begin
            req_last_d = cmd_word[31];
            state_d = S_IDLE;
         end
         S_IDLE: if (req) begin
            a_d = op_a;
            b_d = op_b;
            opc_d = cmd_word[2:0];
            req_last_d = cmd_word[31];
            busy_d = 1'b1;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            mul_start = opc_q == OP_MUL;
            stg_d = opc_q == OP_ADD ? add_s[31:0] :
                    opc_q == OP_SUB ? a_q - b_q :
                    opc_q == OP_ACC ? acc_s[31:0] :
                    opc_q == OP_CLR ? 32'd0 : res_q;
            stg_cy_d = opc_q == OP_ADD ? add_s[32] : opc_q == OP_SUB ? a_q < b_q : acc_s[32];
            state_d = opc_q == OP_MUL ? S_MUL : S_DONE;
         end
         S_MUL: state_d = mul_done ? S_DONE : S_MUL;
         S_DONE: begin
            res_d = opc_q == OP_MUL ? mul_p : stg_q;
            acc_d = opc_q == OP_ACC ? stg_q : opc_q == OP_CLR ? 32'd0 : acc_q;
            ovr_d = opc_q == OP_CLR ? 1'b0 : ovr_q;
            cy_d = arith ? stg_cy_q : cy_q;
            ill_d = opc_q > OP_CLR;
            lop_d = opc_q;
            ack_d = ~ack_q;
            cnt_d = cnt_q + CNT_W'(1);
            busy_d = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_INIT;
      endcase
      // a toggle seen while busy is flagged here and picked up once back in IDLE
      if (busy_q && req) ovr_d = 1'b1;
   end
   always_ff @(posedge okClk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_INIT;
         req_last_q <= 1'b0;
         a_q <= '0;
         b_q <= '0;
         opc_q <= '0;
         acc_q <= '0;
         stg_q <= '0;
         stg_cy_q <= 1'b0;
         res_q <= '0;
         cnt_q <= '0;
         ack_q <= 1'b0;
         busy_q <= 1'b0;
         ill_q <= 1'b0;
         ovr_q <= 1'b0;
         cy_q <= 1'b0;
         lop_q <= '0;
      end else begin
         state_q <= state_d;
         req_last_q <= req_last_d;
         a_q <= a_d;
         b_q <= b_d;
         opc_q <= opc_d;
         acc_q <= acc_d;
         stg_q <= stg_d;
         stg_cy_q <= stg_cy_d;
         res_q <= res_d;
         cnt_q <= cnt_d;
         ack_q <= ack_d;
         busy_q <= busy_d;
         ill_q <= ill_d;
         ovr_q <= ovr_d;
         cy_q <= cy_d;
         lop_q <= lop_d;
      end
   end
   always_comb begin
      status = '0;
      status[ST_ACK] = ack_q;
      status[ST_BUSY] = busy_q;
      status[ST_ILL] = ill_q;
      status[ST_OVR] = ovr_q;
      status[ST_CY] = cy_q;
      status[ST_OPC_LSB +: 3] = lop_q;
      status[CNT_W-1:0] = cnt_q;
   end
   assign result = res_q;
endmodule

// File: tb/tb_wire_cmd_responder.sv
// tb_wire_cmd_responder: directed commands with a queued scoreboard checked on every ack toggle.
module tb_wire_cmd_responder;
   import wire_cmd_pkg::*;
   logic okClk = 1'b0;
   logic rst_n = 1'b1;
   logic [31:0] cmd_word = 32'h8000_0000;
   logic [31:0] op_a = '0, op_b = '0, result, status;
   logic mon_ack = 1'b0;
   int checks = 0, failures = 0;
   logic [63:0] exp_q[$];
   always #5 okClk = ~okClk;
   wire_cmd_responder dut (
      .okClk(okClk),
      .rst_n(rst_n),
      .cmd_word(cmd_word),
      .op_a(op_a),
      .op_b(op_b),
      .result(result),
      .status(status)
   );
   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   // monitor: every ack toggle out of reset must match the oldest queued expectation
   initial forever begin
      @(negedge okClk);
      if (rst_n && status[31] !== mon_ack) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_ack: result %h status %h with no command pending", result, status);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            check("sb_result", result, e[63:32]);
            check("sb_status", status, e[31:0]);
         end
      end
      mon_ack = status[31];
   end
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic [31:0] es);
      logic t;
      t = ~cmd_word[31];
      op_a = a;
      op_b = b;
      cmd_word = {t, 28'd0, op};
      exp_q.push_back({er, es});
   endtask
   task automatic wait_ack(input int lat, input string nm);
      int n;
      logic a0;
      logic [31:0] r0;
      logic bad;
      n = 0;
      a0 = status[31];
      r0 = result;
      bad = 1'b0;
      while (n < 100) begin
         @(negedge okClk);
         n++;
         if (status[31] !== a0) break;
         if (status[30] !== 1'b1 || result !== r0) bad = 1'b1;
      end
      check({nm, "_latency"}, 32'(n), 32'(lat));
      check({nm, "_busy_hold"}, {31'd0, bad}, 32'd0);
   endtask
   initial begin
      #2 rst_n = 1'b0;
      repeat (3) @(negedge okClk);
      check("rst_result", result, 32'd0);
      check("rst_status", status, 32'd0);
      rst_n = 1'b1;
      repeat (10) @(negedge okClk);
      check("no_spurious_result", result, 32'd0);
      check("no_spurious_status", status, 32'd0);
      issue(OP_ADD, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'h8800_0001);
      wait_ack(3, "add");
      issue(OP_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 32'h0900_0002);
      wait_ack(3, "sub");
      issue(OP_MUL, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 32'h8A00_0003);
      wait_ack(35, "mul");
      issue(OP_ACC, 32'd10, 32'd0, 32'd10, 32'h0300_0004);
      wait_ack(3, "acc10");
      issue(OP_ACC, 32'd20, 32'd0, 32'd30, 32'h8300_0005);
      wait_ack(3, "acc20");
      issue(3'd6, 32'd99, 32'd1, 32'd30, 32'h2600_0006);
      wait_ack(3, "illegal");
      issue(OP_MUL, 32'd3, 32'd4, 32'd12, 32'h9200_0007);
      exp_q.push_back({32'd37, 32'h1300_0008});
      repeat (5) @(negedge okClk);
      cmd_word = {~cmd_word[31], 28'd0, OP_ACC};
      op_a = 32'd7;
      op_b = 32'd0;
      wait_ack(30, "mul_overrun");
      wait_ack(3, "pending_acc");
      issue(OP_CLR, 32'd0, 32'd0, 32'd0, 32'h8400_0009);
      wait_ack(3, "clr");
      issue(OP_ACC, 32'd5, 32'd0, 32'd5, 32'h0300_000A);
      wait_ack(3, "acc_after_clr");
      issue(OP_ADD, 32'd1, 32'd1, 32'd2, 32'h9000_000B);
      @(negedge okClk);
      cmd_word[31] = ~cmd_word[31];
      @(negedge okClk);
      cmd_word[31] = ~cmd_word[31];
      wait_ack(1, "double_toggle");
      repeat (10) @(negedge okClk);
      check("double_toggle_idle", status, 32'h9000_000B);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      issue(OP_MUL, 32'd6, 32'd7, 32'd0, 32'd0);
      void'(exp_q.pop_back());
      repeat (10) @(negedge okClk);
      rst_n = 1'b0;
      #1;
      check("abort_result", result, 32'd0);
      check("abort_status", status, 32'd0);
      repeat (2) @(negedge okClk);
      rst_n = 1'b1;
      repeat (40) @(negedge okClk);
      check("abort_no_ack", status, 32'd0);
      issue(OP_ACC, 32'd9, 32'd0, 32'd9, 32'h8300_0001);
      wait_ack(3, "acc_after_reset");
      repeat (3) @(negedge okClk);
      check("final_queue", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
